// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg -- shared types and constants for the stopwatch control slice.
//   state_t                 : FSM state encoding (IDLE/RUNNING/PAUSED, 2'b11 illegal)
//   DEBOUNCE_CYCLES_DEFAULT : default debounce hold time (10 ms at 100 MHz)
//   DEBOUNCE_CNT_W          : width of the debounce hold counter
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int DEBOUNCE_CNT_W          = 20;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// btn_debounce -- 2-flop synchronizer, hold-time debouncer and press detector
// for one raw pushbutton.
//   clock  : system clock, rising edge
//   reset  : asynchronous active-low reset
//   btn    : raw asynchronous button level (active-high)
//   press  : registered one-cycle pulse on the debounced 0->1 edge
// Press-to-pulse latency is 2 + DEBOUNCE_CYCLES + 1 cycles.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                      sync_p0;
    logic                      sync_p1;
    logic                      stable;
    logic                      stable_d;
    logic [DEBOUNCE_CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            // synchronizer stage boundary
            sync_p0  <= btn;
            sync_p1  <= sync_p0;
            // The counter only runs while the synchronized level differs from
            // the accepted level; any bounce back to the accepted level
            // restarts the hold time from zero.
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // edge-detect stage boundary: release produces nothing
            stable_d <= stable;
            press    <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl -- start/stop/clear control for a stopwatch counter.
//   clock     : 100 MHz system clock, rising edge
//   reset     : asynchronous active-low reset
//   btn_start : raw start/stop pushbutton (active-high)
//   btn_clear : raw clear pushbutton (active-high)
//   start     : registered run level, 1 exactly while state == RUNNING
//   clear     : registered one-cycle pulse that zeroes the downstream digits
//   state     : current FSM state (00 IDLE, 01 RUNNING, 10 PAUSED)
// Optional feature, macro STOPWATCH_LAP_EN:
//   btn_lap   : raw lap pushbutton, debounced like the others
//   hold      : lap display hold, toggled by lap presses while RUNNING
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic       start,
    output logic       clear,
    output logic [1:0] state
`ifdef STOPWATCH_LAP_EN
    ,
    input  logic       btn_lap,
    output logic       hold
`endif
);

    logic   start_evt;
    logic   clear_evt;
    state_t st;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clock (clock),
        .reset (reset),
        .btn   (btn_start),
        .press (start_evt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clock (clock),
        .reset (reset),
        .btn   (btn_clear),
        .press (clear_evt)
    );

`ifdef STOPWATCH_LAP_EN
    logic lap_evt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clock (clock),
        .reset (reset),
        .btn   (btn_lap),
        .press (lap_evt)
    );
`endif

    assign state = st;

    // start and clear are registered alongside the state so that start tracks
    // RUNNING exactly and clear can only fire on a transition into IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st    <= ST_IDLE;
            start <= 1'b0;
            clear <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            hold  <= 1'b0;
`endif
        end else begin
            clear <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            hold  <= 1'b0;
`endif
            case (st)
                ST_IDLE: begin
                    // clear has priority over start when both arrive together
                    if (clear_evt) begin
                        st    <= ST_IDLE;
                        start <= 1'b0;
                        clear <= 1'b1;
                    end else if (start_evt) begin
                        st    <= ST_RUNNING;
                        start <= 1'b1;
                    end else begin
                        start <= 1'b0;
                    end
                end
                ST_RUNNING: begin
                    // clear is ignored while running; start pauses
                    if (start_evt) begin
                        st    <= ST_PAUSED;
                        start <= 1'b0;
                    end else begin
                        start <= 1'b1;
`ifdef STOPWATCH_LAP_EN
                        hold  <= lap_evt ? ~hold : hold;
`endif
                    end
                end
                ST_PAUSED: begin
                    if (clear_evt) begin
                        st    <= ST_IDLE;
                        start <= 1'b0;
                        clear <= 1'b1;
                    end else if (start_evt) begin
                        st    <= ST_RUNNING;
                        start <= 1'b1;
                    end else begin
                        start <= 1'b0;
                    end
                end
                default: begin
                    st    <= ST_IDLE;
                    start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl -- directed vectors for stopwatch_ctrl with DEBOUNCE_CYCLES=4.
// Event latency from a button change applied at a falling edge: 7 rising edges
// to the debounced press pulse, state/start/clear update on the 8th.
module tb_stopwatch_ctrl;

    localparam int DB = 4;

    logic       clock;
    logic       reset;
    logic       btn_start;
    logic       btn_clear;
    logic       start;
    logic       clear;
    logic [1:0] state;
`ifdef STOPWATCH_LAP_EN
    logic       btn_lap;
    logic       hold;
`endif

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .start     (start),
        .clear     (clear),
        .state     (state)
`ifdef STOPWATCH_LAP_EN
        ,
        .btn_lap   (btn_lap),
        .hold      (hold)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       bs;
        logic       bc;
        int         n;
        logic [1:0] st;
        logic       run;
        logic       clr;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic bs, logic bc, int n, logic [1:0] st,
                                logic run, logic clr, string name);
        vec_t v;
        v.bs = bs; v.bc = bc; v.n = n; v.st = st; v.run = run; v.clr = clr; v.name = name;
        return v;
    endfunction

    task automatic check(string name, logic [1:0] got, logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all(string name, logic [1:0] st, logic run, logic clr);
        check({name, ".state"}, state, st);
        check({name, ".start"}, {1'b0, start}, {1'b0, run});
        check({name, ".clear"}, {1'b0, clear}, {1'b0, clr});
    endtask

    task automatic wait_neg(int n);
        for (int k = 0; k < n; k++) @(negedge clock);
    endtask

    initial begin
        vecs.push_back(mk(1, 0,  7, 2'b00, 0, 0, "pre_event"));
        vecs.push_back(mk(1, 0,  1, 2'b01, 1, 0, "start_cycle8"));
        vecs.push_back(mk(1, 0, 12, 2'b01, 1, 0, "held_one_event"));
        vecs.push_back(mk(0, 0, 10, 2'b01, 1, 0, "release_no_event"));
        vecs.push_back(mk(1, 0,  8, 2'b10, 0, 0, "pause"));
        vecs.push_back(mk(0, 0, 10, 2'b10, 0, 0, "pause_release"));
        vecs.push_back(mk(1, 0,  8, 2'b01, 1, 0, "resume"));
        vecs.push_back(mk(0, 0, 10, 2'b01, 1, 0, "resume_release"));
        vecs.push_back(mk(0, 1,  8, 2'b01, 1, 0, "run_clear_ignored"));
        vecs.push_back(mk(0, 1,  1, 2'b01, 1, 0, "run_clear_no_pulse"));
        vecs.push_back(mk(0, 0, 10, 2'b01, 1, 0, "run_clear_release"));
        vecs.push_back(mk(1, 1,  8, 2'b10, 0, 0, "run_both_start_wins"));
        vecs.push_back(mk(0, 0, 10, 2'b10, 0, 0, "run_both_release"));
        vecs.push_back(mk(1, 1,  7, 2'b10, 0, 0, "pause_both_pre"));
        vecs.push_back(mk(1, 1,  1, 2'b00, 0, 1, "pause_both_clear_wins"));
        vecs.push_back(mk(1, 1,  1, 2'b00, 0, 0, "pause_both_pulse_once"));
        vecs.push_back(mk(0, 0, 10, 2'b00, 0, 0, "pause_both_release"));
        vecs.push_back(mk(0, 1,  8, 2'b00, 0, 1, "idle_clear_pulse"));
        vecs.push_back(mk(0, 1,  1, 2'b00, 0, 0, "idle_clear_once"));
        vecs.push_back(mk(0, 0, 10, 2'b00, 0, 0, "idle_clear_release"));
        vecs.push_back(mk(1, 0,  8, 2'b01, 1, 0, "seq_start1"));
        vecs.push_back(mk(0, 0, 10, 2'b01, 1, 0, "seq_rel1"));
        vecs.push_back(mk(1, 0,  8, 2'b10, 0, 0, "seq_start2"));
        vecs.push_back(mk(0, 0, 10, 2'b10, 0, 0, "seq_rel2"));
        vecs.push_back(mk(0, 1,  7, 2'b10, 0, 0, "seq_clear_pre"));
        vecs.push_back(mk(0, 1,  1, 2'b00, 0, 1, "seq_clear_pulse"));
        vecs.push_back(mk(0, 1,  1, 2'b00, 0, 0, "seq_clear_once"));
        vecs.push_back(mk(0, 0, 10, 2'b00, 0, 0, "seq_release"));

        reset     = 1'b0;
        btn_start = 1'b0;
        btn_clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        btn_lap   = 1'b0;
`endif
        wait_neg(3);
        check_all("reset", 2'b00, 0, 0);
        reset = 1'b1;
        wait_neg(2);
        check_all("after_reset", 2'b00, 0, 0);

        foreach (vecs[i]) begin
            btn_start = vecs[i].bs;
            btn_clear = vecs[i].bc;
            wait_neg(vecs[i].n);
            check_all(vecs[i].name, vecs[i].st, vecs[i].run, vecs[i].clr);
        end

        // Bouncing start button: never stable for DB cycles, so no event.
        for (int i = 0; i < 30; i++) begin
            btn_start = ((i / 2) % 2 == 0);
            wait_neg(1);
            check("bounce.start", {1'b0, start}, 2'b00);
        end
        btn_start = 1'b0;
        wait_neg(10);
        check_all("bounce_settled", 2'b00, 0, 0);

        // Reset mid-debounce while RUNNING, button kept held through release.
        btn_start = 1'b1;
        wait_neg(8);
        check_all("rst_seq_run", 2'b01, 1, 0);
        btn_start = 1'b0;
        wait_neg(10);
        btn_start = 1'b1;
        wait_neg(4);
        reset = 1'b0;
        #1;
        check_all("rst_async", 2'b00, 0, 0);
        wait_neg(1);
        reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            wait_neg(1);
            check_all("rst_held_wait", 2'b00, 0, 0);
        end
        wait_neg(1);
        check_all("rst_held_event", 2'b01, 1, 0);
        wait_neg(12);
        check_all("rst_held_once", 2'b01, 1, 0);
        btn_start = 1'b0;
        wait_neg(10);

`ifdef STOPWATCH_LAP_EN
        check("lap.hold_init", {1'b0, hold}, 2'b00);
        btn_lap = 1'b1;
        wait_neg(7);
        check("lap.hold_pre", {1'b0, hold}, 2'b00);
        wait_neg(1);
        check("lap.hold_set", {1'b0, hold}, 2'b01);
        btn_lap = 1'b0;
        wait_neg(10);
        check("lap.hold_kept", {1'b0, hold}, 2'b01);
        btn_start = 1'b1;
        wait_neg(8);
        check("lap.pause_state", state, 2'b10);
        check("lap.hold_cleared", {1'b0, hold}, 2'b00);
        btn_start = 1'b0;
        wait_neg(10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of clock cycles a raw button must hold a new level before it is accepted (10 ms at 100 MHz).
REQ-002 The block SHALL have port clock, input, 1, the single system clock (100 MHz); all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, with asynchronous assertion and active-low polarity.
REQ-004 The block SHALL have port btn_start, input, 1, the raw asynchronous start/stop pushbutton (active-high).
REQ-005 The block SHALL have port btn_clear, input, 1, the raw asynchronous clear pushbutton (active-high).
REQ-006 The block SHALL have port start, output, 1, a run level that drives the downstream stopwatch counter enable.
REQ-007 The block SHALL have port clear, output, 1, a one-cycle pulse that zeroes the downstream digit registers.
REQ-008 The block SHALL have port state, output, 2, the current FSM state encoding.

Function
REQ-009 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Each synchronized button SHALL be debounced: a 20-bit counter reloads on any level mismatch, and the stable level updates only after DEBOUNCE_CYCLES consecutive matching cycles.
REQ-011 A press event SHALL be a single-cycle pulse on the debounced 0->1 edge; release SHALL generate no event, and a held button SHALL yield exactly one event.
REQ-012 Press-to-event latency SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
REQ-013 The FSM SHALL have the states IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10; 2'b11 is illegal and returns to IDLE on the next cycle.
REQ-014 In IDLE, a start event SHALL move to RUNNING, and a clear event SHALL remain in IDLE and pulse clear.
REQ-015 In RUNNING, a start event SHALL move to PAUSED, and a clear event SHALL be ignored.
REQ-016 In PAUSED, a start event SHALL move to RUNNING, and a clear event SHALL move to IDLE and pulse clear.
REQ-017 On simultaneous start and clear events in IDLE or PAUSED, clear SHALL win, with the next state IDLE; in RUNNING, start SHALL win.
REQ-018 start SHALL be registered and equal to 1 exactly when state==RUNNING, with no combinational path from the inputs.
REQ-019 clear SHALL be registered, asserted for exactly one cycle following the accepted clear event, and never asserted while start==1.

Reset
REQ-020 While reset==0, the state SHALL be IDLE, start=0, clear=0, debounce counters=0, and synchronizer and stable levels=0.
REQ-021 Reset asserted mid-debounce or in RUNNING SHALL abort immediately, with no event or clear pulse generated.
REQ-022 Reset deassertion SHALL be consumed synchronously; a button already held at release SHALL produce one event after full debounce.

Configuration
REQ-023 Macro STOPWATCH_LAP_EN, when defined, SHALL add input btn_lap (raw, debounced identically) and output hold (1 bit).
REQ-024 With STOPWATCH_LAP_EN defined, a lap event SHALL toggle hold in RUNNING only; any transition out of RUNNING and any clear SHALL force hold=0; hold SHALL reset to 0.
REQ-025 Without STOPWATCH_LAP_EN, neither port SHALL exist and the behaviour SHALL be exactly REQ-009..REQ-022.

Structure
REQ-026 Package stopwatch_pkg SHALL hold the state typedef and encodings, DEBOUNCE_CYCLES_DEFAULT, and the debounce counter width constant (20).
REQ-027 Sub-module btn_debounce (sync + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.

Verification (DEBOUNCE_CYCLES=4 for all scenarios)
REQ-028 Hold btn_start high for 20 cycles -> exactly one event, start=1 at cycle 8 after the press, state=01.
REQ-029 Toggle btn_start every 2 cycles for 30 cycles, then hold low -> no event, start stays 0.
REQ-030 Sequence start, start, clear with full debounce between each -> states 01, 10, 00; clear high for exactly 1 cycle after the third event.
REQ-031 In RUNNING, press clear -> state stays 01, clear stays 0; press start and clear together -> state 10, clear 0.
REQ-032 In PAUSED, press start and clear together -> state 00, single clear pulse, start 0.
REQ-033 Pull reset low for 1 cycle mid-debounce in RUNNING -> start=0 and state=00 asynchronously, no clear pulse; with STOPWATCH_LAP_EN, a lap event in RUNNING sets hold=1, and a subsequent start event sets hold=0.
